aes_round_engine: RTL
=====================

# aes_round_engine

Iterative AES-128/192/256 encryption engine: accepts one 128-bit plaintext block per transaction over a valid/ready handshake and performs the initial AddRoundKey plus Nr rounds, one round per clock, using the existing SubBytes/ShiftRows/MixColumns/AddRoundKey submodules. It replaces the free-running, reset-less round block with a reset FSM: per-block key-length mode, round-key index output and output backpressure. Round keys come from an external key-schedule store addressed by `rk_idx`.

## Interface
- `ALLOW_192`, default 1: mode 2'b01 accepted when 1; rejected when 0.
- `ALLOW_256`, default 1: modes 2'b10/2'b11 accepted when 1; rejected when 0.
- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `in_valid`  in  1  input block offered.
- `in_ready`  out  1  engine can take a block this cycle.
- `in_block`  in  128  plaintext, byte 0 in [127:120].
- `in_mode`  in  2  key length: 00 → Nr=10, 01 → Nr=12, 10/11 → Nr=14.
- `rk_idx`  out  4  round-key index requested this cycle (0..Nr).
- `rk`  in  128  round key for `rk_idx`, valid combinationally in the same cycle.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  consumer takes result.
- `out_block`  out  128  ciphertext, held stable while `out_valid && !out_ready`.
- `out_err`  out  1  qualifies `out_block`: 1 = mode rejected, `out_block` = 0.
- `busy`  out  1  high in ROUND or DONE.

## Operation
- FSM states: IDLE, ROUND, DONE. Registers: `st` (128), `cnt` (4), `nr` (4), `err` (1).
- IDLE: `in_ready`=1, `rk_idx`=0. On `in_valid`: latch `nr` from `in_mode`. If the mode is rejected by the parameters: `err`←1, `st`←0, go to DONE. Otherwise `st`←`in_block ^ rk`, `cnt`←1, `err`←0, go to ROUND.
- ROUND: `rk_idx`=`cnt`.
  - If `cnt<nr`: `st`←AddRoundKey(MixColumns(ShiftRows(SubBytes(st))), rk), `cnt`←`cnt+1`.
  - If `cnt==nr`: `st`←ShiftRows(SubBytes(st)) ^ rk (final round, no MixColumns), go to DONE.
- DONE: `out_valid`=1, `out_block`=`st`, `out_err`=`err`.
  - On `out_ready`: if `in_valid` too, perform the IDLE acceptance in the same cycle (back-to-back); else go to IDLE.
  - `in_ready` = `out_ready` in DONE; `rk_idx`=0 in DONE.
- `in_ready`=0 in ROUND; `in_valid` there is ignored and the block is not consumed.
- `in_mode` and `in_block` are sampled only on the accepting edge; later changes have no effect on the block in flight.
- `rk_idx` never exceeds `nr`; `cnt` never wraps.
- `out_block` in IDLE/ROUND = `st` (don't-care, `out_valid`=0).

## Timing
- Reset: state IDLE, `st`=0, `cnt`=0, `nr`=10, `err`=0. Outputs after reset: `in_ready`=1, `out_valid`=0, `out_block`=0, `out_err`=0, `busy`=0, `rk_idx`=0.
- `rst` wins over all other inputs. A block in flight is discarded and no output is produced.
- Latency: if the acceptance edge is E0, `out_valid` rises after edge E(nr). That is 10/12/14 cycles for modes 00/01/1x.
- Throughput with `out_ready` held high: one block per nr+1 cycles (acceptance overlaps the DONE cycle).
- Rejected mode: `out_valid` rises after E0+1 with `out_err`=1.
- `out_valid` stays high and `out_block` stays stable until the `out_ready` handshake.
- `busy` is the registered complement of IDLE.

## Test plan
- AES-128 (FIPS-197 C.1): pt 00112233445566778899aabbccddeeff, key 000102…0f, model-supplied `rk`, mode 00 → `out_block`=69c4e0d86a7b0430d8cdb78070b4c55a, `out_valid` after 10 cycles, `rk_idx` sequence 0..10.
- AES-192 (C.2) mode 01 → dda97ca4864cdfe06eaf70a0ec0d7191 after 12 cycles. AES-256 (C.3) with mode 10 and with mode 11 → 8ea2b7ca516745bfeafc49904b496089 after 14 cycles.
- Backpressure: hold `out_ready`=0 for 5 cycles after `out_valid`, toggle `in_valid`/`in_block` meanwhile → output stable, no input accepted. Then `out_ready`=1 with `in_valid`=1 → next block accepted that same cycle and 4 back-to-back C.1 blocks complete in 44 cycles.
- Mode change mid-flight: accept mode 00, drive `in_mode`=10 during ROUND → still 10 rounds, C.1 result.
- Build `ALLOW_256`=0, send mode 10 → `out_valid` after 1 cycle with `out_err`=1, `out_block`=0. Then mode 00 still yields the C.1 result.
- Assert `rst` at round 5 of a C.1 block → next cycle `in_ready`=1, `busy`=0, no `out_valid`. A fresh block then completes correctly.

Source files
------------

// File: rtl/aes_round_engine.sv
// Iterative AES-128/192/256 encryptor: one round per clock, with a valid/ready block interface.
// Round keys come from an external schedule store that is addressed through rk_idx.
module aes_round_engine #(
    parameter bit ALLOW_192 = 1'b1,
    parameter bit ALLOW_256 = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_block,
    input  logic [1:0]   in_mode,
    output logic [3:0]   rk_idx,
    input  logic [127:0] rk,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_block,
    output logic         out_err,
    output logic         busy
);

    typedef enum logic [1:0] {S_IDLE, S_ROUND, S_DONE} state_t;

    state_t       r_state, w_state_nxt;
    logic [127:0] r_st, w_st_nxt;
    logic [3:0]   r_cnt, w_cnt_nxt;
    logic [3:0]   r_nr, w_nr_nxt;
    logic         r_err, w_err_nxt;
    logic         r_busy;
    logic         w_accept, w_reject;
    logic [3:0]   w_mode_nr;
    logic [127:0] w_sr, w_mc;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int unsigned i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // S-box as GF(2^8) inverse (a^254, which maps 0 to 0) followed by the affine map.
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] v;
        v = 8'h01;
        for (int unsigned i = 0; i < 8; i++) begin
            v = gf_mul(v, v);
            if (i != 7) v = gf_mul(v, a);
        end
        return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int unsigned i = 0; i < 16; i++)
            o[127-8*i -: 8] = sbox(s[127-8*i -: 8]);
        return o;
    endfunction

    // Byte i sits at row i%4, column i/4; row r rotates left by r columns.
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int unsigned r = 0; r < 4; r++)
            for (int unsigned c = 0; c < 4; c++)
                o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c+r)%4)) -: 8];
        return o;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int unsigned c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            o[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            o[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            o[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return o;
    endfunction

    assign w_sr      = shift_rows(sub_bytes(r_st));
    assign w_mc      = mix_columns(w_sr);
    assign w_mode_nr = (in_mode == 2'b00) ? 4'd10 : (in_mode == 2'b01) ? 4'd12 : 4'd14;
    assign w_reject  = ((in_mode == 2'b01) && !ALLOW_192) || (in_mode[1] && !ALLOW_256);
    assign in_ready  = (r_state == S_IDLE) || ((r_state == S_DONE) && out_ready);
    assign w_accept  = in_valid && in_ready;

    always_comb begin
        w_state_nxt = r_state;
        w_st_nxt    = r_st;
        w_cnt_nxt   = r_cnt;
        w_nr_nxt    = r_nr;
        w_err_nxt   = r_err;
        rk_idx      = '0;
        case (r_state)
            S_IDLE: ;
            S_ROUND: begin
                rk_idx = r_cnt;
                if (r_cnt < r_nr) begin
                    w_st_nxt  = w_mc ^ rk;
                    w_cnt_nxt = r_cnt + 4'd1;
                end else begin
                    w_st_nxt    = w_sr ^ rk;
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: if (out_ready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
        // Acceptance is shared by IDLE and the back-to-back DONE handshake.
        if (w_accept) begin
            w_nr_nxt = w_mode_nr;
            if (w_reject) begin
                w_err_nxt   = 1'b1;
                w_st_nxt    = '0;
                w_state_nxt = S_DONE;
            end else begin
                w_st_nxt    = in_block ^ rk;
                w_cnt_nxt   = 4'd1;
                w_err_nxt   = 1'b0;
                w_state_nxt = S_ROUND;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_st    <= '0;
            r_cnt   <= '0;
            r_nr    <= 4'd10;
            r_err   <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_st    <= w_st_nxt;
            r_cnt   <= w_cnt_nxt;
            r_nr    <= w_nr_nxt;
            r_err   <= w_err_nxt;
            r_busy  <= (w_state_nxt != S_IDLE);
        end
    end

    assign out_valid = (r_state == S_DONE);
    assign out_block = r_st;
    assign out_err   = r_err && (r_state == S_DONE);
    assign busy      = r_busy;

endmodule
